cpu_axi_bridge: RTL and testbench



---
 rtl/cpu_axi_bridge.sv | 183 ++++++++++++++++++
 tb/tb_cpu_axi_bridge.sv | 387 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_axi_bridge.sv
// Bridges the core's fetch and load/store SRAM-like ports onto one AXI3 master,
// one outstanding transaction at a time, data requests winning over fetches.
module cpu_axi_bridge #(
    parameter logic [3:0] ID_INST = 4'd0,
    parameter logic [3:0] ID_DATA = 4'd1
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic [31:0] data_addr,
    input  logic [1:0]  data_size,
    input  logic [3:0]  data_wen,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [3:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic        arvalid,
    input  logic        arready,

    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,

    output logic [3:0]  awid,
    output logic [31:0] awaddr,
    output logic [3:0]  awlen,
    output logic [2:0]  awsize,
    output logic [1:0]  awburst,
    output logic        awvalid,
    input  logic        awready,

    output logic [3:0]  wid,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,

    input  logic [3:0]  bid,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_ADDR,
        S_RD_DATA,
        S_WR_REQ,
        S_WR_RESP,
        S_DONE
    } state_t;

    state_t      state, state_next;
    logic [31:0] addr_q;
    logic [1:0]  size_q;
    logic [3:0]  wen_q;
    logic [31:0] wdata_q;
    logic        owner_data_q;
    logic        aw_done_q, w_done_q;
    logic [31:0] inst_rdata_q, data_rdata_q;

    logic        data_grant, inst_grant;
    logic        aw_fin, w_fin;

    // Response-side IDs, status and last flag carry nothing this bridge needs.
    logic        unused_inputs;
    assign unused_inputs = ^{rid, rresp, rlast, bid, bresp};

    assign aw_fin = aw_done_q | (awvalid & awready);
    assign w_fin  = w_done_q  | (wvalid & wready);

    always_comb begin
        state_next = state;
        data_grant = 1'b0;
        inst_grant = 1'b0;
        case (state)
            S_IDLE: begin
                if (resetn && data_req) begin
                    data_grant = 1'b1;
                    state_next = (|data_wen) ? S_WR_REQ : S_RD_ADDR;
                end else if (resetn && inst_req) begin
                    inst_grant = 1'b1;
                    state_next = S_RD_ADDR;
                end
            end
            S_RD_ADDR: if (arready) state_next = S_RD_DATA;
            S_RD_DATA: if (rvalid)  state_next = S_DONE;
            S_WR_REQ:  if (aw_fin && w_fin) state_next = S_WR_RESP;
            S_WR_RESP: if (bvalid)  state_next = S_DONE;
            S_DONE:    state_next = S_IDLE;
            default:   state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state        <= S_IDLE;
            addr_q       <= '0;
            size_q       <= '0;
            wen_q        <= '0;
            wdata_q      <= '0;
            owner_data_q <= 1'b0;
            aw_done_q    <= 1'b0;
            w_done_q     <= 1'b0;
            inst_rdata_q <= '0;
            data_rdata_q <= '0;
        end else begin
            state <= state_next;
            if (data_grant) begin
                addr_q       <= data_addr;
                size_q       <= data_size;
                wen_q        <= data_wen;
                wdata_q      <= data_wdata;
                owner_data_q <= 1'b1;
            end else if (inst_grant) begin
                addr_q       <= inst_addr;
                size_q       <= 2'd2;
                wen_q        <= '0;
                wdata_q      <= '0;
                owner_data_q <= 1'b0;
            end
            // Per-channel completion flags live only while both handshakes are pending.
            if (state == S_WR_REQ && state_next == S_WR_REQ) begin
                aw_done_q <= aw_fin;
                w_done_q  <= w_fin;
            end else begin
                aw_done_q <= 1'b0;
                w_done_q  <= 1'b0;
            end
            if (state == S_RD_DATA && rvalid) begin
                if (owner_data_q) data_rdata_q <= rdata;
                else              inst_rdata_q <= rdata;
            end
        end
    end

    assign data_addr_ok = data_grant;
    assign inst_addr_ok = inst_grant;
    assign data_data_ok = (state == S_DONE) &&  owner_data_q;
    assign inst_data_ok = (state == S_DONE) && !owner_data_q;
    assign inst_rdata   = inst_rdata_q;
    assign data_rdata   = data_rdata_q;

    assign arid    = owner_data_q ? ID_DATA : ID_INST;
    assign araddr  = addr_q;
    assign arlen   = 4'd0;
    assign arsize  = {1'b0, size_q};
    assign arburst = 2'b01;
    assign arvalid = (state == S_RD_ADDR);
    assign rready  = (state == S_RD_DATA);

    assign awid    = ID_DATA;
    assign awaddr  = addr_q;
    assign awlen   = 4'd0;
    assign awsize  = {1'b0, size_q};
    assign awburst = 2'b01;
    assign awvalid = (state == S_WR_REQ) && !aw_done_q;

    assign wid     = ID_DATA;
    assign wdata   = wdata_q;
    assign wstrb   = wen_q;
    assign wlast   = 1'b1;
    assign wvalid  = (state == S_WR_REQ) && !w_done_q;
    assign bready  = (state == S_WR_RESP);

endmodule

// File: tb/tb_cpu_axi_bridge.sv
// Directed bench for cpu_axi_bridge: the bench plays both the core and the AXI slave.
module tb_cpu_axi_bridge;

    logic        clk = 1'b0;
    logic        resetn;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req;
    logic [31:0] data_addr;
    logic [1:0]  data_size;
    logic [3:0]  data_wen;
    logic [31:0] data_wdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [3:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid, arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast, rvalid, rready;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [3:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid, awready;
    logic [3:0]  wid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast, wvalid, wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid, bready;

    int errors = 0;
    int checks = 0;

    int n_inst_dok = 0, n_data_dok = 0, n_ar = 0, n_both_aok = 0;

    cpu_axi_bridge dut (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_addr(inst_addr),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_addr(data_addr), .data_size(data_size),
        .data_wen(data_wen), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    always #5 clk = ~clk;

    // Inputs change 2 units after the rising edge, so the falling edge sees settled values.
    always @(negedge clk) begin
        if (inst_data_ok) n_inst_dok++;
        if (data_data_ok) n_data_dok++;
        if (arvalid && arready) n_ar++;
        if (inst_addr_ok && data_addr_ok) n_both_aok++;
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_fetch(input logic [31:0] a, input logic [31:0] d);
        inst_req = 1'b1; inst_addr = a;
        step();
        inst_req = 1'b0; arready = 1'b1;
        step();
        arready = 1'b0; rvalid = 1'b1; rdata = d;
        step();
        rvalid = 1'b0;
        step();
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        inst_req = 1'b1; inst_addr = 32'h1234_5678;
        data_req = 1'b0; data_addr = '0; data_size = '0; data_wen = '0; data_wdata = '0;
        arready = 0; rid = 0; rdata = 0; rresp = 0; rlast = 1; rvalid = 0;
        awready = 0; wready = 0; bid = 0; bresp = 0; bvalid = 0;
        step(); step();
        #1;
        checks++;
        if ({arvalid, awvalid, wvalid, rready, bready} !== 5'b0) begin
            errors++; $display("FAIL reset_axi_valids: got %b expected 00000", {arvalid, awvalid, wvalid, rready, bready});
        end
        checks++;
        if ({inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok} !== 4'b0) begin
            errors++; $display("FAIL reset_oks: got %b expected 0000", {inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok});
        end
        checks++;
        if (inst_rdata !== 32'h0 || data_rdata !== 32'h0) begin
            errors++; $display("FAIL reset_rdata: got %h/%h expected 0/0", inst_rdata, data_rdata);
        end
        checks++;
        if (araddr !== 32'h0 || wstrb !== 4'h0 || wdata !== 32'h0) begin
            errors++; $display("FAIL reset_latched: got %h/%h/%h expected 0", araddr, wstrb, wdata);
        end
        checks++;
        if ({arlen, awlen, arburst, awburst, wlast, wid, awid} !== {4'd0, 4'd0, 2'b01, 2'b01, 1'b1, 4'd1, 4'd1}) begin
            errors++; $display("FAIL const_outputs: got %h", {arlen, awlen, arburst, awburst, wlast, wid, awid});
        end
        inst_req = 1'b0;
        resetn = 1'b1;
        step();
    endtask

    task automatic test_fetch();
        int dok0;
        dok0 = n_inst_dok;
        inst_req = 1'b1; inst_addr = 32'hBFC0_0000;
        #1;
        checks++;
        if (inst_addr_ok !== 1'b1 || data_addr_ok !== 1'b0) begin
            errors++; $display("FAIL fetch_addr_ok: got %b%b expected 10", inst_addr_ok, data_addr_ok);
        end
        step();
        inst_req = 1'b0; arready = 1'b1;
        #1;
        checks++;
        if (arvalid !== 1'b1 || araddr !== 32'hBFC0_0000 || arid !== 4'd0 || arsize !== 3'd2) begin
            errors++; $display("FAIL fetch_ar: got v=%b a=%h id=%0d sz=%0d expected 1 bfc00000 0 2", arvalid, araddr, arid, arsize);
        end
        step();
        arready = 1'b0; rvalid = 1'b1; rdata = 32'h3C08_0001;
        #1;
        checks++;
        if (rready !== 1'b1 || arvalid !== 1'b0 || inst_data_ok !== 1'b0) begin
            errors++; $display("FAIL fetch_rd_data: got rready=%b arvalid=%b dok=%b expected 1 0 0", rready, arvalid, inst_data_ok);
        end
        step();
        rvalid = 1'b0;
        #1;
        checks++;
        if (inst_data_ok !== 1'b1 || inst_rdata !== 32'h3C08_0001 || data_data_ok !== 1'b0) begin
            errors++; $display("FAIL fetch_done: got dok=%b rdata=%h ddok=%b expected 1 3c080001 0", inst_data_ok, inst_rdata, data_data_ok);
        end
        step();
        checks++;
        if (n_inst_dok - dok0 !== 1 || inst_data_ok !== 1'b0) begin
            errors++; $display("FAIL fetch_pulse_count: got %0d expected 1", n_inst_dok - dok0);
        end
    endtask

    task automatic test_priority();
        inst_req = 1'b1; inst_addr = 32'h0000_0100;
        data_req = 1'b1; data_addr = 32'h8000_1000; data_size = 2'd2; data_wen = 4'b0;
        #1;
        checks++;
        if (data_addr_ok !== 1'b1 || inst_addr_ok !== 1'b0) begin
            errors++; $display("FAIL prio_grant: got d=%b i=%b expected 1 0", data_addr_ok, inst_addr_ok);
        end
        step();
        data_req = 1'b0; arready = 1'b1;
        #1;
        checks++;
        if (arid !== 4'd1 || araddr !== 32'h8000_1000 || arsize !== 3'd2 || inst_addr_ok !== 1'b0) begin
            errors++; $display("FAIL prio_ar: got id=%0d a=%h sz=%0d iok=%b expected 1 80001000 2 0", arid, araddr, arsize, inst_addr_ok);
        end
        step();
        arready = 1'b0; rvalid = 1'b1; rdata = 32'hDEAD_BEEF;
        step();
        rvalid = 1'b0;
        #1;
        checks++;
        if (data_data_ok !== 1'b1 || data_rdata !== 32'hDEAD_BEEF || inst_addr_ok !== 1'b0 || inst_data_ok !== 1'b0) begin
            errors++; $display("FAIL prio_data_done: got dok=%b rdata=%h iaok=%b idok=%b", data_data_ok, data_rdata, inst_addr_ok, inst_data_ok);
        end
        step();
        checks++;
        if (inst_addr_ok !== 1'b1) begin
            errors++; $display("FAIL prio_inst_next: got %b expected 1", inst_addr_ok);
        end
        step();
        inst_req = 1'b0; arready = 1'b1;
        #1;
        checks++;
        if (arid !== 4'd0 || araddr !== 32'h0000_0100) begin
            errors++; $display("FAIL prio_inst_ar: got id=%0d a=%h expected 0 00000100", arid, araddr);
        end
        step();
        arready = 1'b0; rvalid = 1'b1; rdata = 32'h1111_2222;
        step();
        rvalid = 1'b0;
        #1;
        checks++;
        if (inst_data_ok !== 1'b1 || inst_rdata !== 32'h1111_2222 || data_rdata !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL prio_inst_done: got ok=%b i=%h d=%h expected 1 11112222 deadbeef", inst_data_ok, inst_rdata, data_rdata);
        end
        step();
        checks++;
        if (n_both_aok !== 0) begin
            errors++; $display("FAIL prio_dual_addr_ok: got %0d expected 0", n_both_aok);
        end
    endtask

    task automatic test_byte_store();
        data_req = 1'b1; data_addr = 32'h8000_2002; data_size = 2'd0;
        data_wen = 4'b0100; data_wdata = 32'h00AB_0000;
        #1;
        checks++;
        if (data_addr_ok !== 1'b1) begin
            errors++; $display("FAIL store_addr_ok: got %b expected 1", data_addr_ok);
        end
        step();
        data_req = 1'b0; data_wen = 4'b0; awready = 1'b1;
        #1;
        checks++;
        if (awvalid !== 1'b1 || wvalid !== 1'b1 || awaddr !== 32'h8000_2002 || awsize !== 3'd0 ||
            wstrb !== 4'b0100 || wdata !== 32'h00AB_0000 || awid !== 4'd1 || arvalid !== 1'b0) begin
            errors++; $display("FAIL store_req: got av=%b wv=%b a=%h sz=%0d st=%b wd=%h", awvalid, wvalid, awaddr, awsize, wstrb, wdata);
        end
        step();
        awready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) wready = 1'b1;
            #1;
            checks++;
            if (awvalid !== 1'b0 || wvalid !== 1'b1 || bready !== 1'b0) begin
                errors++; $display("FAIL store_w_wait%0d: got av=%b wv=%b br=%b expected 0 1 0", i, awvalid, wvalid, bready);
            end
            step();
        end
        wready = 1'b0; bvalid = 1'b1;
        #1;
        checks++;
        if (bready !== 1'b1 || wvalid !== 1'b0 || data_data_ok !== 1'b0) begin
            errors++; $display("FAIL store_resp: got br=%b wv=%b dok=%b expected 1 0 0", bready, wvalid, data_data_ok);
        end
        step();
        bvalid = 1'b0;
        #1;
        checks++;
        if (data_data_ok !== 1'b1 || inst_data_ok !== 1'b0) begin
            errors++; $display("FAIL store_done: got dok=%b idok=%b expected 1 0", data_data_ok, inst_data_ok);
        end
        step();
        checks++;
        if (data_data_ok !== 1'b0) begin
            errors++; $display("FAIL store_pulse_end: got %b expected 0", data_data_ok);
        end
    endtask

    task automatic test_stall();
        int dok0;
        dok0 = n_inst_dok;
        inst_req = 1'b1; inst_addr = 32'h0000_1000;
        step();
        inst_req = 1'b0; arready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (arvalid !== 1'b1 || araddr !== 32'h0000_1000) begin
                errors++; $display("FAIL stall_ar%0d: got v=%b a=%h expected 1 00001000", i, arvalid, araddr);
            end
            step();
        end
        arready = 1'b1;
        step();
        arready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (rready !== 1'b1 || arvalid !== 1'b0 || inst_data_ok !== 1'b0) begin
                errors++; $display("FAIL stall_r%0d: got rr=%b av=%b dok=%b expected 1 0 0", i, rready, arvalid, inst_data_ok);
            end
            step();
        end
        rvalid = 1'b1; rdata = 32'hCAFE_F00D;
        step();
        rvalid = 1'b0;
        #1;
        checks++;
        if (inst_data_ok !== 1'b1 || inst_rdata !== 32'hCAFE_F00D) begin
            errors++; $display("FAIL stall_done: got ok=%b d=%h expected 1 cafef00d", inst_data_ok, inst_rdata);
        end
        step(); step();
        checks++;
        if (n_inst_dok - dok0 !== 1) begin
            errors++; $display("FAIL stall_one_pulse: got %0d expected 1", n_inst_dok - dok0);
        end
    endtask

    task automatic test_reset_mid();
        int dok0;
        dok0 = n_inst_dok + n_data_dok;
        inst_req = 1'b1; inst_addr = 32'h0000_2000;
        step();
        inst_req = 1'b0; arready = 1'b1;
        step();
        arready = 1'b0;
        resetn = 1'b0;
        step();
        #1;
        checks++;
        if ({arvalid, awvalid, wvalid, rready, bready, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok} !== 9'b0 ||
            inst_rdata !== 32'h0 || araddr !== 32'h0) begin
            errors++; $display("FAIL midreset_outputs: got %b rdata=%h a=%h expected zeros", {arvalid, awvalid, wvalid, rready, bready, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}, inst_rdata, araddr);
        end
        resetn = 1'b1;
        step(); step();
        checks++;
        if (n_inst_dok + n_data_dok !== dok0) begin
            errors++; $display("FAIL midreset_no_pulse: got %0d expected %0d", n_inst_dok + n_data_dok, dok0);
        end
        do_fetch(32'h0000_3000, 32'h0BAD_CAFE);
        checks++;
        if (inst_rdata !== 32'h0BAD_CAFE || n_inst_dok - dok0 + n_data_dok !== 1) begin
            errors++; $display("FAIL midreset_refetch: got d=%h pulses=%0d expected 0badcafe 1", inst_rdata, n_inst_dok + n_data_dok - dok0);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_rd [3];
        logic [31:0] got_ar [$];
        logic [31:0] got_rd [$];
        int          ar_cyc [$];
        int          accepted;
        exp_rd[0] = 32'h1111_0000;
        exp_rd[1] = 32'h1111_0004;
        exp_rd[2] = 32'h1111_0008;
        accepted = 0;
        arready = 1'b1;
        for (int cyc = 0; cyc < 40 && got_rd.size() < 3; cyc++) begin
            rvalid = 1'b0;
            inst_req = (accepted < 3);
            inst_addr = 32'(accepted * 4);
            #1;
            if (arvalid) begin
                got_ar.push_back(araddr);
                ar_cyc.push_back(cyc);
            end
            if (inst_data_ok) got_rd.push_back(inst_rdata);
            if (inst_addr_ok) accepted++;
            if (rready) begin
                rvalid = 1'b1;
                rdata = 32'h1111_0000 | got_ar[got_ar.size()-1];
            end
            step();
        end
        rvalid = 1'b0; arready = 1'b0; inst_req = 1'b0;
        checks++;
        if (got_ar.size() !== 3 || got_rd.size() !== 3) begin
            errors++; $display("FAIL b2b_count: got ar=%0d rd=%0d expected 3 3", got_ar.size(), got_rd.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (got_ar[i] !== 32'(i * 4) || got_rd[i] !== exp_rd[i]) begin
                    errors++; $display("FAIL b2b_order%0d: got a=%h d=%h expected %h %h", i, got_ar[i], got_rd[i], 32'(i * 4), exp_rd[i]);
                end
            end
            for (int i = 1; i < 3; i++) begin
                checks++;
                if (ar_cyc[i] - ar_cyc[i-1] < 4) begin
                    errors++; $display("FAIL b2b_spacing%0d: got %0d expected >=4", i, ar_cyc[i] - ar_cyc[i-1]);
                end
            end
        end
        step();
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_priority();
        test_byte_store();
        test_stall();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
